// File: rtl/alu_pkg.sv
// Shared ALU definitions: default data width, fixed pipeline latency,
// flag bit positions and opcodes used by both the ALU and its result collector.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_LAT   = 2;

  localparam int CARRY = 3;
  localparam int ZERO  = 2;
  localparam int OVF   = 1;
  localparam int SIGN  = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with explicit occupancy count; the count, not the
// pointers, tells full from empty so pointers simply wrap modulo DEPTH.
module alu_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DW-1:0]          wdata_i,
  output logic [DW-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign empty_o = (cnt_q == {CNT_W{1'b0}});
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign do_pop_s  = pop_i && !empty_o && !flush_i;
  assign do_push_s = push_i && (!full_o || do_pop_s) && !flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = {PTR_W{1'b0}};
      rd_d  = {PTR_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_d = wr_q + PTR_W'(1);
      if (do_pop_s)  rd_d = rd_q + PTR_W'(1);
      if (do_push_s && !do_pop_s) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!do_push_s && do_pop_s) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= {PTR_W{1'b0}};
      rd_q  <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {DW{1'b0}};
    end else if (do_push_s) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Collects ALU results behind a valid/tag delay line matched to the ALU
// latency, queues them for a valid/ready consumer and issues credits upstream.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int LAT   = ALU_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic [TAG_W-1:0]       issue_tag,
  output logic                   issue_ready,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [3:0]             out_flags,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] out_count,
  output logic                   drop_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DW    = WIDTH + 4 + TAG_W;
  localparam int SUM_W = CNT_W + $clog2(LAT + 1) + 1;

  logic [LAT-1:0]            vld_q, vld_d;
  logic [LAT-1:0][TAG_W-1:0] tag_q, tag_d;
  logic                      drop_err_q, drop_err_d;
  logic                      issue_fire_s, push_s, pop_s, full_s, empty_s, overflow_s;
  logic [SUM_W-1:0]          inflight_s;
  logic [DW-1:0]             wdata_s, rdata_s;
  logic [3:0]                flags_s;

  // Credit counts queued entries plus everything still travelling through the ALU.
  always_comb begin
    inflight_s = {SUM_W{1'b0}};
    for (int i = 0; i < LAT; i++) inflight_s = inflight_s + SUM_W'(vld_q[i]);
  end

  assign issue_ready  = (SUM_W'(out_count) + inflight_s) < SUM_W'(DEPTH);
  assign issue_fire_s = issue_valid && issue_ready;
  assign push_s       = vld_q[LAT-1];
  assign pop_s        = out_valid && out_ready;
  assign overflow_s   = push_s && full_s && !pop_s && !flush;

  assign flags_s = {alu_flags[CARRY], alu_flags[ZERO], alu_flags[OVF], alu_flags[SIGN]};
  assign wdata_s = {alu_result, flags_s, tag_q[LAT-1]};

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (flush) begin
      vld_d = {LAT{1'b0}};
    end else begin
      vld_d[0] = issue_fire_s;
      tag_d[0] = issue_tag;
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_comb begin
    drop_err_d = drop_err_q;
    if ((issue_valid && !issue_ready) || overflow_s) begin
      drop_err_d = 1'b1;
    end else begin
      drop_err_d = drop_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= {LAT{1'b0}};
      tag_q      <= '{default: {TAG_W{1'b0}}};
      drop_err_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      drop_err_q <= drop_err_d;
    end
  end

  alu_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wdata_s),
    .rdata_o (rdata_s),
    .count_o (out_count),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign out_valid  = !empty_s;
  assign out_result = rdata_s[DW-1 -: WIDTH];
  assign out_flags  = rdata_s[TAG_W +: 4];
  assign out_tag    = rdata_s[TAG_W-1:0];
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer, driving it from a two-stage ADD-only
// ALU so results line up with the buffer's fixed latency.
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       issue_valid = 1'b0;
  logic [3:0] issue_tag = 4'd0;
  logic       issue_ready;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic [3:0] out_tag;
  logic [2:0] out_count;
  logic       drop_err;

  logic [7:0] alu_a = 8'd0, alu_b = 8'd0, a_q, b_q;
  int passed = 0;
  int total  = 0;

  // Fill/drain vectors with hand-computed sums and {carry,zero,ovf,sign}.
  logic [7:0] fa [5] = '{8'hFF, 8'h7F, 8'h10, 8'h80, 8'h0F};
  logic [7:0] fb [5] = '{8'h01, 8'h01, 8'h20, 8'h80, 8'hF0};
  logic [7:0] er [5] = '{8'h00, 8'h80, 8'h30, 8'h00, 8'hFF};
  logic [3:0] ef [5] = '{4'b1100, 4'b0011, 4'b0000, 4'b1110, 4'b0001};

  alu_result_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .issue_ready(issue_ready), .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_tag(out_tag), .out_count(out_count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] add_ref(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    add_ref = {s[8], s[7:0] == 8'd0, (a[7] == b[7]) && (s[7] != a[7]), s[7], s[7:0]};
  endfunction

  // Stimulus ALU: operands registered at the issue edge, result one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= 8'd0; b_q <= 8'd0; alu_result <= 8'd0; alu_flags <= 4'd0;
    end else begin
      a_q <= alu_a; b_q <= alu_b;
      {alu_flags, alu_result} <= add_ref(a_q, b_q);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input logic [3:0] t, input logic [7:0] a, input logic [7:0] b);
    issue_valid = 1'b1; issue_tag = t; alu_a = a; alu_b = b;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else passed++;
    total++; if (out_result !== 8'd0) $display("FAIL rst_out_result: got %0h want 0", out_result); else passed++;
    total++; if (out_flags !== 4'd0) $display("FAIL rst_out_flags: got %0h want 0", out_flags); else passed++;
    total++; if (out_tag !== 4'd0) $display("FAIL rst_out_tag: got %0h want 0", out_tag); else passed++;
    total++; if (out_count !== 3'd0) $display("FAIL rst_out_count: got %0d want 0", out_count); else passed++;
    total++; if (drop_err !== 1'b0) $display("FAIL rst_drop_err: got %0b want 0", drop_err); else passed++;
    total++; if (issue_ready !== 1'b1) $display("FAIL rst_issue_ready: got %0b want 1", issue_ready); else passed++;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    issue(4'd3, 8'd5, 8'd7);
    total++; if (out_valid !== 1'b0) $display("FAIL single_early_k: got %0b want 0", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL single_early_k1: got %0b want 0", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", out_valid); else passed++;
    total++; if (out_result !== 8'd12) $display("FAIL single_result: got %0d want 12", out_result); else passed++;
    total++; if (out_flags !== 4'b0000) $display("FAIL single_flags: got %b want 0000", out_flags); else passed++;
    total++; if (out_tag !== 4'd3) $display("FAIL single_tag: got %0d want 3", out_tag); else passed++;
    tick();
    total++; if (out_count !== 3'd0) $display("FAIL single_count_after: got %0d want 0", out_count); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int t = 0; t < 4; t++) issue(4'(t), fa[t], fb[t]);
    total++; if (issue_ready !== 1'b0) $display("FAIL fill_ready_low: got %0b want 0", issue_ready); else passed++;
    total++; if (out_count !== 3'd2) $display("FAIL fill_count_mid: got %0d want 2", out_count); else passed++;
    issue(4'd5, 8'h11, 8'h22);
    total++; if (drop_err !== 1'b1) $display("FAIL fill_drop_err: got %0b want 1", drop_err); else passed++;
    tick();
    total++; if (out_count !== 3'd4) $display("FAIL fill_count_full: got %0d want 4", out_count); else passed++;
    total++; if (issue_ready !== 1'b0) $display("FAIL fill_ready_full: got %0b want 0", issue_ready); else passed++;
    total++; if (out_tag !== 4'd0) $display("FAIL fill_head_tag: got %0d want 0", out_tag); else passed++;
    total++; if (out_result !== er[0]) $display("FAIL fill_head_result: got %0h want %0h", out_result, er[0]); else passed++;
    total++; if (out_flags !== ef[0]) $display("FAIL fill_head_flags: got %b want %b", out_flags, ef[0]); else passed++;
  endtask

  task automatic test_full_traffic();
    int n = 0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_count !== 3'd3) $display("FAIL full_pop_count: got %0d want 3", out_count); else passed++;
    total++; if (issue_ready !== 1'b1) $display("FAIL full_ready_back: got %0b want 1", issue_ready); else passed++;
    issue(4'd4, fa[4], fb[4]);
    total++; if (issue_ready !== 1'b0) $display("FAIL full_ready_inflight: got %0b want 0", issue_ready); else passed++;
    tick(); tick();
    total++; if (out_count !== 3'd4) $display("FAIL full_refill_count: got %0d want 4", out_count); else passed++;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
      if (out_valid) begin
        total++; if (out_tag !== 4'(n + 1)) $display("FAIL drain_tag: got %0d want %0d", out_tag, n + 1); else passed++;
        total++; if (out_result !== er[n+1]) $display("FAIL drain_result: got %0h want %0h", out_result, er[n+1]); else passed++;
        total++; if (out_flags !== ef[n+1]) $display("FAIL drain_flags: got %b want %b", out_flags, ef[n+1]); else passed++;
        n++;
      end
      tick();
    end
    out_ready = 1'b0;
    total++; if (n !== 4) $display("FAIL drain_timeout: got %0d entries want 4", n); else passed++;
    total++; if (out_count !== 3'd0) $display("FAIL drain_count: got %0d want 0", out_count); else passed++;
  endtask

  task automatic test_stream();
    logic [7:0] sa [16];
    logic [7:0] sb [16];
    logic [11:0] exp_v;
    int sent = 0;
    int got = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      sa[i] = 8'(i * 37 + 3);
      sb[i] = 8'(200 - i * 11);
    end
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp_v = add_ref(sa[got], sb[got]);
        total++; if (out_tag !== 4'(got)) $display("FAIL stream_tag: got %0d want %0d", out_tag, got); else passed++;
        total++; if ({out_flags, out_result} !== exp_v) $display("FAIL stream_data: got %0h want %0h", {out_flags, out_result}, exp_v); else passed++;
        got++;
      end
      if (sent < 16 && issue_ready) begin
        issue_valid = 1'b1; issue_tag = 4'(sent); alu_a = sa[sent]; alu_b = sb[sent];
        sent++;
      end else begin
        issue_valid = 1'b0;
      end
      tick();
    end
    issue_valid = 1'b0; out_ready = 1'b0;
    total++; if (got !== 16) $display("FAIL stream_timeout: got %0d delivered want 16", got); else passed++;
    total++; if (drop_err !== 1'b0) $display("FAIL stream_drop_err: got %0b want 0", drop_err); else passed++;
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    issue(4'd1, 8'd1, 8'd2);
    issue(4'd2, 8'd3, 8'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", out_valid); else passed++;
    total++; if (out_count !== 3'd0) $display("FAIL flush_count: got %0d want 0", out_count); else passed++;
    total++; if (issue_ready !== 1'b1) $display("FAIL flush_ready: got %0b want 1", issue_ready); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL flush_late_push: got %0d cycles valid want 0", seen); else passed++;
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    out_ready = 1'b0;
    issue(4'd6, 8'd1, 8'd1);
    issue(4'd7, 8'd2, 8'd2);
    issue(4'd8, 8'd3, 8'd3);
    tick();
    total++; if (out_count !== 3'd2) $display("FAIL midop_pre_count: got %0d want 2", out_count); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL midop_valid: got %0b want 0", out_valid); else passed++;
    total++; if (out_count !== 3'd0) $display("FAIL midop_count: got %0d want 0", out_count); else passed++;
    total++; if ({out_result, out_flags, out_tag} !== 16'd0) $display("FAIL midop_data: got %0h want 0", {out_result, out_flags, out_tag}); else passed++;
    total++; if (issue_ready !== 1'b1) $display("FAIL midop_ready: got %0b want 1", issue_ready); else passed++;
    total++; if (drop_err !== 1'b0) $display("FAIL midop_drop_err: got %0b want 0", drop_err); else passed++;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midop_lost: got %0d cycles valid want 0", seen); else passed++;
    out_ready = 1'b1;
    issue(4'd9, 8'd200, 8'd100);
    tick(); tick();
    total++; if (out_valid !== 1'b1) $display("FAIL resume_valid: got %0b want 1", out_valid); else passed++;
    total++; if (out_result !== 8'd44) $display("FAIL resume_result: got %0d want 44", out_result); else passed++;
    total++; if (out_flags !== 4'b1000) $display("FAIL resume_flags: got %b want 1000", out_flags); else passed++;
    total++; if (out_tag !== 4'd9) $display("FAIL resume_tag: got %0d want 9", out_tag); else passed++;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_traffic();
    test_stream();
    test_flush();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream collector for the 8-bit pipelined ALU. Tracks which ALU cycles carry real operations through a valid/tag delay line matched to the ALU's fixed 2-cycle latency. Captures result and flags into a small FIFO and presents them to the consumer over a valid/ready handshake. Also drives credit-based back-pressure to the issuing stage, so no ALU result is ever lost.

## Interface
- WIDTH, 8, ALU data width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- TAG_W, 4, issue tag width
- LAT, 2, ALU issue-to-result latency in clk edges (fixed)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of FIFO and in-flight tracking
- issue_valid  in  1  operation presented to ALU this cycle
- issue_tag  in  TAG_W  tag accompanying the operation
- issue_ready  out  1  credit available; issuer may assert issue_valid
- alu_result  in  WIDTH  ALU result output
- alu_flags  in  4  {carry, zero, overflow, sign} from ALU
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_result  out  WIDTH  head result
- out_flags  out  4  head flags, same order as alu_flags
- out_tag  out  TAG_W  head tag
- out_count  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_err  out  1  sticky; issue_valid seen while issue_ready low

## Operation
- Accepted issue: issue_valid && issue_ready at a clk edge. Only accepted issues enter the delay line. issue_valid with issue_ready low is ignored and sets drop_err.
- The delay line is LAT stages of {valid, tag}. Stage LAT aligns with alu_result/alu_flags.
- Push: stage-LAT valid pushes {alu_result, alu_flags, tag} at the next edge.
- Pop: out_valid && out_ready.
- Credit: issue_ready = (out_count + inflight) < DEPTH, where inflight = number of valid delay stages. Combinational from registered state only, with no path from issue_valid or out_ready.
- Simultaneous push and pop: legal at any occupancy, including full. The count is unchanged and pointers advance.
- Push into a full FIFO cannot occur when credit is honoured. If it does occur, the push is discarded and drop_err is set.
- Pointers wrap modulo DEPTH. out_count distinguishes full from empty.
- flush: clears delay-line valids, pointers and count in one edge. A pop in the same cycle is ignored. drop_err is not cleared.
- The FIFO output is the head entry; data is stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid 0, out_result 0, out_flags 0, out_tag 0, out_count 0, drop_err 0, issue_ready 1, all delay stages invalid.
- Cycle timing for an issue accepted at edge k:
  - The ALU registers its operands at edge k.
  - The ALU result is visible after edge k+1.
  - The push happens at edge k+2, and out_valid is high after edge k+2 if the FIFO was empty.
  - Issue-to-out_valid latency is therefore 3 edges.
- Back-to-back issues give one push per edge, in issue order.
- issue_ready reflects the state after the current edge's pushes, pops and issues; it updates one cycle after the event.
- Reset mid-operation: everything clears asynchronously and in-flight operations are lost. The ALU shares rst.
- Throughput is one op per cycle when out_ready is held high.

## Structure
- Shared package alu_pkg:
  - flag bit-index constants (CARRY=3, ZERO=2, OVF=1, SIGN=0)
  - WIDTH default
  - ALU latency constant LAT=2
  - opcode localparams, shared with the ALU
- Sub-module alu_sync_fifo (parameterised WIDTH+4+TAG_W, DEPTH) holds the storage, pointers and count.
- The top level holds the delay line, credit logic and drop_err.

## Test plan
- Single op: issue tag 3 with ADD 5+7, out_ready=1 → out_valid rises 3 edges later with out_result 12, flags carry0 zero0 ovf0 sign0, tag 3; out_count returns to 0.
- Fill: out_ready=0, issue tags 0,1,2,3 back-to-back → issue_ready low after the 4th issue; out_count reaches 4 at 2 edges after the last issue; a 5th issue_valid is ignored and sets drop_err.
- Full with simultaneous traffic: at full, assert out_ready=1 for one cycle → one pop; issue_ready returns high; the next issue lands in order (tags 1,2,3,4 drained).
- Stream: 16 ops with random out_ready → all 16 tags delivered in order, none lost, drop_err stays 0.
- Flush: issue 2 ops, assert flush on the edge after the second issue → out_valid stays 0, out_count 0, issue_ready 1, and no late push appears.
- Reset mid-op: assert rst asynchronously with 2 entries queued and 1 in flight → all outputs at reset values immediately; normal operation resumes after release.
